// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: boot-time Avalon-MM reader of the system-ID slave.
// Reads ID then timestamp, compares to build constants, flags pass/fail/timeout.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'd1715151045,
    parameter bit          CHECK_TS     = 1'b1,
    parameter int          READ_LATENCY = 0,
    parameter int          WAIT_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] sysid_value,
    output logic [31:0] timestamp_value
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        DONE,
        ERR
    } state_t;

    localparam logic [3:0]  LAT_N     = 4'(READ_LATENCY);
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_TIMEOUT - 1);

    state_t      state;
    logic [3:0]  lat_cnt;
    logic [15:0] wait_cnt;

    logic rd_state;
    logic lat_state;
    logic cap_ts;
    logic capture;
    logic id_eq;
    logic ts_eq;

    // Capture happens on the accepting cycle (no latency) or N cycles later.
    assign rd_state  = (state == RD_ID) || (state == RD_TS);
    assign lat_state = (state == LAT_ID) || (state == LAT_TS);
    assign cap_ts    = (state == RD_TS) || (state == LAT_TS);
    assign capture   = (rd_state && !avm_waitrequest && (LAT_N == 4'd0))
                     || (lat_state && (lat_cnt == LAT_N));
    assign id_eq     = (avm_readdata == EXPECTED_ID);
    assign ts_eq     = (avm_readdata == EXPECTED_TS);

    // Check sequencer: read strobes, stall/latency counters and result flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            lat_cnt         <= '0;
            wait_cnt        <= '0;
            avm_address     <= 1'b0;
            avm_read        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            id_match        <= 1'b0;
            ts_match        <= 1'b0;
            pass            <= 1'b0;
            timeout         <= 1'b0;
            sysid_value     <= '0;
            timestamp_value <= '0;
        end else if (capture) begin
            wait_cnt <= '0;
            lat_cnt  <= '0;
            if (cap_ts) begin
                timestamp_value <= avm_readdata;
                ts_match        <= ts_eq;
                pass            <= id_match & (ts_eq | ~CHECK_TS);
                avm_read        <= 1'b0;
                busy            <= 1'b0;
                done            <= 1'b1;
                state           <= DONE;
            end else begin
                sysid_value <= avm_readdata;
                id_match    <= id_eq;
                avm_read    <= 1'b1;
                avm_address <= 1'b1;
                state       <= RD_TS;
            end
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state           <= RD_ID;
                        lat_cnt         <= '0;
                        wait_cnt        <= '0;
                        avm_address     <= 1'b0;
                        avm_read        <= 1'b1;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        id_match        <= 1'b0;
                        ts_match        <= 1'b0;
                        pass            <= 1'b0;
                        timeout         <= 1'b0;
                        sysid_value     <= '0;
                        timestamp_value <= '0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        wait_cnt <= '0;
                        lat_cnt  <= 4'd1;
                        state    <= (state == RD_ID) ? LAT_ID : LAT_TS;
                    end else if (wait_cnt == WAIT_LAST) begin
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        pass     <= 1'b0;
                        state    <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                LAT_ID, LAT_TS: begin
                    lat_cnt <= lat_cnt + 4'd1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: random and directed checks of the sysid boot checker.
// Two instances: zero-latency strict checker and latency-2 informational-ts checker.
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'd1715151045;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [1:0]       start;
    logic [1:0]       wreq;
    logic [1:0][31:0] rdata;
    logic [1:0]       addr;
    logic [1:0]       rd;
    logic [1:0]       busy;
    logic [1:0]       done;
    logic [1:0]       idm;
    logic [1:0]       tsm;
    logic [1:0]       pass;
    logic [1:0]       to;
    logic [1:0][31:0] sid;
    logic [1:0][31:0] tsv;

    logic [1:0]       e_busy;
    logic [1:0]       e_done;
    logic [1:0]       e_read;
    logic [1:0]       e_addr;
    logic [1:0]       e_idm;
    logic [1:0]       e_tsm;
    logic [1:0]       e_pass;
    logic [1:0]       e_to;
    logic [1:0][31:0] e_sid;
    logic [1:0][31:0] e_tsv;

    int  checks = 0;
    int  errors = 0;
    bit  chk_on = 1'b0;
    int  busy_cyc [2];
    int  read_cyc [2];

    sysid_boot_checker #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .CHECK_TS    (1'b1),
        .READ_LATENCY(0),
        .WAIT_TIMEOUT(16)
    ) u0 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start[0]),
        .avm_address    (addr[0]),
        .avm_read       (rd[0]),
        .avm_waitrequest(wreq[0]),
        .avm_readdata   (rdata[0]),
        .busy           (busy[0]),
        .done           (done[0]),
        .id_match       (idm[0]),
        .ts_match       (tsm[0]),
        .pass           (pass[0]),
        .timeout        (to[0]),
        .sysid_value    (sid[0]),
        .timestamp_value(tsv[0])
    );

    sysid_boot_checker #(
        .EXPECTED_ID (EXP_ID),
        .EXPECTED_TS (EXP_TS),
        .CHECK_TS    (1'b0),
        .READ_LATENCY(2),
        .WAIT_TIMEOUT(255)
    ) u1 (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start[1]),
        .avm_address    (addr[1]),
        .avm_read       (rd[1]),
        .avm_waitrequest(wreq[1]),
        .avm_readdata   (rdata[1]),
        .busy           (busy[1]),
        .done           (done[1]),
        .id_match       (idm[1]),
        .ts_match       (tsm[1]),
        .pass           (pass[1]),
        .timeout        (to[1]),
        .sysid_value    (sid[1]),
        .timestamp_value(tsv[1])
    );

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 0;
    endfunction

    function automatic int wto_of(input int k);
        return (k == 1) ? 255 : 16;
    endfunction

    function automatic bit chk_of(input int k);
        return (k == 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic cmp(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h at %0t",
                     nm, k, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                cmp("busy", k, 32'(busy[k]), 32'(e_busy[k]));
                cmp("done", k, 32'(done[k]), 32'(e_done[k]));
                cmp("avm_read", k, 32'(rd[k]), 32'(e_read[k]));
                if (e_read[k])
                    cmp("avm_address", k, 32'(addr[k]), 32'(e_addr[k]));
                cmp("id_match", k, 32'(idm[k]), 32'(e_idm[k]));
                cmp("ts_match", k, 32'(tsm[k]), 32'(e_tsm[k]));
                cmp("pass", k, 32'(pass[k]), 32'(e_pass[k]));
                cmp("timeout", k, 32'(to[k]), 32'(e_to[k]));
                cmp("sysid_value", k, sid[k], e_sid[k]);
                cmp("timestamp_value", k, tsv[k], e_tsv[k]);
            end
        end
    end

    // Observed busy/read cycle counts for the literal duration checks.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (busy[k]) busy_cyc[k]++;
            if (rd[k]) read_cyc[k]++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic zero_exp(input int k);
        e_busy[k] = 1'b0;
        e_done[k] = 1'b0;
        e_read[k] = 1'b0;
        e_addr[k] = 1'b0;
        e_idm[k]  = 1'b0;
        e_tsm[k]  = 1'b0;
        e_pass[k] = 1'b0;
        e_to[k]   = 1'b0;
        e_sid[k]  = '0;
        e_tsv[k]  = '0;
    endtask

    task automatic model_capture(input int k, input int ph,
                                 input logic [31:0] v);
        if (ph == 0) begin
            e_sid[k]  = v;
            e_idm[k]  = (v == EXP_ID);
            e_read[k] = 1'b1;
            e_addr[k] = 1'b1;
        end else begin
            e_tsv[k]  = v;
            e_tsm[k]  = (v == EXP_TS);
            e_pass[k] = e_idm[k] & (e_tsm[k] | !chk_of(k));
            e_busy[k] = 1'b0;
            e_done[k] = 1'b1;
            e_read[k] = 1'b0;
        end
    endtask

    // One full check: s_id/s_ts stall cycles per read, v_id/v_ts slave data.
    // abort pulses reset_n during the third stalled cycle of the TS read.
    task automatic do_check(input int k, input int s_id, input int s_ts,
                            input logic [31:0] v_id, input logic [31:0] v_ts,
                            input bit abort);
        int s;
        logic [31:0] v;
        int lat;
        int wto;
        lat = lat_of(k);
        wto = wto_of(k);
        start[k] = 1'b1;
        wreq[k]  = 1'($urandom);
        tick();
        start[k] = 1'b0;
        zero_exp(k);
        e_busy[k] = 1'b1;
        e_read[k] = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            s = (ph == 1) ? s_ts : s_id;
            v = (ph == 1) ? v_ts : v_id;
            for (int i = 0; i <= s; i++) begin
                start[k] = 1'($urandom);
                rdata[k] = $urandom;
                if (i < s) begin
                    if (abort && ph == 1 && i == 2) begin
                        reset_n  = 1'b0;
                        start[k] = 1'b0;
                        zero_exp(0);
                        zero_exp(1);
                        tick();
                        reset_n = 1'b1;
                        return;
                    end
                    wreq[k] = 1'b1;
                    tick();
                    if (i == wto - 1) begin
                        e_busy[k] = 1'b0;
                        e_done[k] = 1'b1;
                        e_read[k] = 1'b0;
                        e_to[k]   = 1'b1;
                        e_pass[k] = 1'b0;
                        start[k]  = 1'b0;
                        return;
                    end
                end else begin
                    wreq[k] = 1'b0;
                    if (lat == 0) begin
                        rdata[k] = v;
                        tick();
                    end else begin
                        tick();
                        e_read[k] = 1'b0;
                        for (int j = 1; j <= lat; j++) begin
                            start[k] = 1'($urandom);
                            wreq[k]  = 1'($urandom);
                            rdata[k] = (j == lat) ? v : $urandom;
                            tick();
                        end
                    end
                    model_capture(k, ph, v);
                end
            end
        end
        start[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            wreq  = 2'($urandom);
            rdata[0] = $urandom;
            rdata[1] = $urandom;
            tick();
        end
    endtask

    initial begin
        int b;
        int k;
        int s1;
        int s2;
        logic [31:0] v1;
        logic [31:0] v2;
        busy_cyc[0] = 0;
        busy_cyc[1] = 0;
        read_cyc[0] = 0;
        read_cyc[1] = 0;
        reset_n = 1'b1;
        start   = '0;
        wreq    = '0;
        rdata   = '0;
        zero_exp(0);
        zero_exp(1);
        #2 reset_n = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        idle(2);

        b = busy_cyc[0];
        do_check(0, 0, 0, 32'h0, 32'd1715151045, 1'b0);
        cmp("t1_busy_cycles", 0, 32'(busy_cyc[0] - b), 32'd2);
        cmp("t1_pass", 0, 32'(pass[0]), 32'd1);
        cmp("t1_ts_value", 0, tsv[0], 32'd1715151045);
        do_check(0, 0, 0, 32'h0, EXP_TS, 1'b0);
        cmp("t1_restart_done", 0, 32'(done[0]), 32'd1);
        idle(3);

        do_check(0, 0, 0, 32'h0, 32'h1234_5678, 1'b0);
        cmp("t2_pass_strict", 0, 32'(pass[0]), 32'd0);
        cmp("t2_ts_match", 0, 32'(tsm[0]), 32'd0);
        cmp("t2_ts_value", 0, tsv[0], 32'h1234_5678);
        do_check(1, 0, 0, 32'h0, 32'h1234_5678, 1'b0);
        cmp("t2_pass_info", 1, 32'(pass[1]), 32'd1);
        idle(2);

        b = read_cyc[1];
        do_check(1, 10, 0, 32'h0, EXP_TS, 1'b0);
        cmp("t3_read_cycles", 1, 32'(read_cyc[1] - b), 32'd12);
        cmp("t3_pass", 1, 32'(pass[1]), 32'd1);
        do_check(0, 10, 0, 32'h0, EXP_TS, 1'b0);
        idle(2);

        b = read_cyc[0];
        do_check(0, 100, 0, 32'h0, EXP_TS, 1'b0);
        cmp("t4_read_cycles", 0, 32'(read_cyc[0] - b), 32'd16);
        cmp("t4_timeout", 0, 32'(to[0]), 32'd1);
        cmp("t4_pass", 0, 32'(pass[0]), 32'd0);
        idle(2);
        do_check(1, 0, 300, 32'h0, EXP_TS, 1'b0);
        idle(2);

        b = busy_cyc[1];
        do_check(1, 0, 0, 32'h0, EXP_TS, 1'b0);
        cmp("t5_busy_cycles", 1, 32'(busy_cyc[1] - b), 32'd6);
        cmp("t5_ts_value", 1, tsv[1], 32'd1715151045);
        idle(2);

        do_check(0, 0, 5, 32'h0, EXP_TS, 1'b1);
        cmp("t6_done_after_reset", 0, 32'(done[0]), 32'd0);
        do_check(0, 0, 0, 32'h0, EXP_TS, 1'b0);
        cmp("t6_clean_pass", 0, 32'(pass[0]), 32'd1);
        do_check(1, 1, 5, 32'h0, EXP_TS, 1'b1);
        idle(1);

        for (int n = 0; n < 60; n++) begin
            k  = int'($urandom_range(0, 1));
            s1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                             : int'($urandom_range(0, 2));
            s2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                             : int'($urandom_range(0, 2));
            v1 = $urandom_range(0, 1) ? EXP_ID : $urandom;
            v2 = $urandom_range(0, 1) ? EXP_TS : $urandom;
            do_check(k, s1, s2, v1, v2, 1'b0);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
